tri_state_bus_arbiter: RTL and testbench
========================================

# tri_state_bus_arbiter

Parametrised shared-bus driver that lets NCH requesters take turns driving one WIDTH-bit tri-state bus. It grants the bus round-robin, limits how long one owner keeps it, and inserts high-Z turnaround cycles between owners so two drivers never overlap. It generalises the single-bit, single-enable tri-state buffer into a clocked, multi-channel bus master. It sits wherever several sources share one physical bus.

## Interface
- WIDTH, 8: bus and per-channel data width (>=1).
- NCH, 4: number of requesting channels (>=2).
- TURN_CYC, 1: high-Z turnaround cycles between two owners (>=1).
- MAX_HOLD, 8: maximum DRIVE-state cycles per grant (>=1).
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  reset, asynchronous, active-high.
- req  in  NCH  per-channel bus request, level-sensitive.
- din  in  NCH*WIDTH  channel i data on din[i*WIDTH +: WIDTH].
- gnt  out  NCH  registered one-hot grant; all zero when no owner.
- owner  out  $clog2(NCH)  index of the current or most recent owner.
- bus_en  out  1  high while the bus is actively driven.
- bus  out (tri)  WIDTH  din[owner] when bus_en=1; otherwise all bits Z.

## Operation
- States: IDLE, DRIVE, TURN.
- Round-robin pointer ptr, width $clog2(NCH), reset value 0.
- Arbitration picks the first i with req[i]=1, searching ptr, ptr+1, … modulo NCH.

Arbitration edge:
- Occurs at any rising edge in IDLE, and at the last TURN cycle's edge (turn counter = TURN_CYC-1).
- If any req is high, go to DRIVE with owner = the selected i, gnt = one-hot(i), hold counter = 0.
- Otherwise go to (or stay in) IDLE with gnt = 0.

DRIVE:
- bus_en is combinational: bus_en = (state==DRIVE) & req[owner].
- bus = din[owner] when bus_en=1, else Z.
- A cycle with bus_en=1 is a beat. The hold counter increments every DRIVE cycle.
- Exit to TURN at an edge where req[owner]=0 or hold counter = MAX_HOLD-1.
- On exit: gnt <= 0, ptr <= (owner+1) mod NCH, turn counter <= 0.

TURN:
- gnt = 0, bus_en = 0, bus = Z.
- Lasts exactly TURN_CYC cycles, then takes the arbitration edge.

Other rules:
- A preempted owner that still requests competes normally. If it is the only requester, it regains the bus after TURN_CYC cycles.
- owner holds its value outside DRIVE. Reset value is 0.
- Invariants: at most one gnt bit set. bus is never driven in IDLE or TURN. Between two different owners there are always at least TURN_CYC Z cycles.
- Reset (async, any state): immediately state=IDLE, gnt=0, bus_en=0, bus=Z, owner=0, ptr=0, all counters 0. No clock edge is needed.

## Timing
- Grant latency from IDLE:
  - req[i] rises before edge k.
  - gnt[i]=1 and bus driven in the cycle after edge k.
  - The first beat is therefore one cycle after the request.
- Gap between owners:
  - The last DRIVE cycle is followed by exactly TURN_CYC Z cycles.
  - The next owner drives in the very next cycle if any request is pending.
  - With no request pending, the block goes TURN → IDLE, plus one cycle of grant latency.
- Maximum tenure: MAX_HOLD DRIVE cycles per grant.
- Release:
  - When the owner drops req, bus goes Z in the same cycle (combinational).
  - gnt clears at the next edge.
- Counter widths cover MAX_HOLD-1 and TURN_CYC-1. Counters wrap only via state transitions, never by overflow.

## Test plan
- Reset: with rst=1 and random req/din, expect gnt=0, bus_en=0, bus=8'hzz, owner=0. Release rst with req=0: state stays IDLE.
- Single requester (WIDTH=8, NCH=4, TURN_CYC=1, MAX_HOLD=8): req=4'b0100 held, din[2]=8'hA5.
  - gnt=4'b0100 one cycle later.
  - 8 cycles bus=8'hA5, then 1 cycle Z.
  - The pattern repeats.
- Full contention: req=4'b1111, each channel drives a distinct byte.
  - Owners 0,1,2,3,0,… each for 8 cycles, separated by 1 Z cycle.
  - gnt is never multi-hot.
- Early release: ch1 granted with req=4'b1010, ch1 drops req after 3 beats.
  - bus goes Z in that same cycle and gnt clears at the next edge.
  - 1 TURN cycle follows, then ch3 is granted (ptr=2).
- TURN_CYC=3, req=4'b0011: between the ch0 and ch1 tenures, exactly 3 Z cycles.
- Async reset mid-DRIVE (ch2 owning, bus=8'h3C): assert rst between clock edges.
  - bus=Z and gnt=0 immediately.
  - After release, the next grant goes to the lowest requesting index, since ptr=0.

Source files
------------

// File: rtl/tri_state_bus_arbiter.sv
// Round-robin owner of a shared tri-state bus. It caps each owner's tenure and
// inserts high-Z turnaround cycles between owners.
module tri_state_bus_arbiter #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned NCH      = 4,
  parameter int unsigned TURN_CYC = 1,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NCH-1:0]           req,
  input  logic [NCH*WIDTH-1:0]     din,
  output logic [NCH-1:0]           gnt,
  output logic [$clog2(NCH)-1:0]   owner,
  output logic                     bus_en,
  output tri   [WIDTH-1:0]         bus
);

  localparam int unsigned PW = $clog2(NCH);
  localparam int unsigned HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam int unsigned TW = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;

  typedef enum logic [1:0] {IDLE, DRIVE, TURN} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   ptr, ptr_nxt, owner_nxt, pick;
  logic [NCH-1:0]  gnt_nxt;
  logic [HW-1:0]   hold_cnt, hold_nxt;
  logic [TW-1:0]   turn_cnt, turn_nxt;
  logic            any_req, owner_req, arb;
  logic [WIDTH-1:0] owner_data;

  // Round-robin pick: scan from farthest to nearest so the nearest request to ptr wins.
  always_comb begin
    pick    = ptr;
    any_req = 1'b0;
    for (int unsigned k = 0; k < NCH; k++) begin
      int unsigned idx;
      idx = (32'(ptr) + NCH - 1 - k) % NCH;
      if (req[PW'(idx)]) begin
        pick    = PW'(idx);
        any_req = 1'b1;
      end
    end
  end

  always_comb begin
    owner_req  = 1'b0;
    owner_data = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (owner == PW'(i)) begin
        owner_req  = req[i];
        owner_data = din[i*WIDTH +: WIDTH];
      end
    end
  end

  // The bus releases in the same cycle the owner drops its request.
  assign bus_en = (state == DRIVE) && owner_req;
  assign bus    = bus_en ? owner_data : {WIDTH{1'bz}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= '0;
      gnt      <= '0;
      ptr      <= '0;
      hold_cnt <= '0;
      turn_cnt <= '0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      gnt      <= gnt_nxt;
      ptr      <= ptr_nxt;
      hold_cnt <= hold_nxt;
      turn_cnt <= turn_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    gnt_nxt   = gnt;
    ptr_nxt   = ptr;
    hold_nxt  = hold_cnt;
    turn_nxt  = turn_cnt;
    arb       = 1'b0;
    case (state)
      IDLE: arb = 1'b1;
      DRIVE: begin
        if (!owner_req || (hold_cnt == HW'(MAX_HOLD - 1))) begin
          state_nxt = TURN;
          gnt_nxt   = '0;
          ptr_nxt   = (owner == PW'(NCH - 1)) ? '0 : owner + PW'(1);
          turn_nxt  = '0;
        end else begin
          hold_nxt = hold_cnt + HW'(1);
        end
      end
      TURN: begin
        if (turn_cnt == TW'(TURN_CYC - 1)) arb = 1'b1;
        else turn_nxt = turn_cnt + TW'(1);
      end
      default: state_nxt = IDLE;
    endcase
    if (arb) begin
      if (any_req) begin
        state_nxt = DRIVE;
        owner_nxt = pick;
        gnt_nxt   = NCH'(1) << pick;
        hold_nxt  = '0;
      end else begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
      end
    end
  end

endmodule

// File: tb/tb_tri_state_bus_arbiter.sv
// Directed bench for tri_state_bus_arbiter: TURN_CYC=1 instance plus a TURN_CYC=3 instance.
module tb_tri_state_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] din = '0;
  logic [3:0]  gnt;
  logic [1:0]  owner;
  logic        bus_en;
  wire  [7:0]  bus;

  logic [3:0]  req3 = '0;
  logic [31:0] din3 = '0;
  logic [3:0]  gnt3;
  logic [1:0]  owner3;
  logic        bus_en3;
  wire  [7:0]  bus3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tri_state_bus_arbiter #(.WIDTH(8), .NCH(4), .TURN_CYC(1), .MAX_HOLD(8)) dut (
    .clk(clk), .rst(rst), .req(req), .din(din),
    .gnt(gnt), .owner(owner), .bus_en(bus_en), .bus(bus)
  );

  tri_state_bus_arbiter #(.WIDTH(8), .NCH(4), .TURN_CYC(3), .MAX_HOLD(8)) dut3 (
    .clk(clk), .rst(rst), .req(req3), .din(din3),
    .gnt(gnt3), .owner(owner3), .bus_en(bus_en3), .bus(bus3)
  );

  task automatic do_reset();
    req  = '0;
    req3 = '0;
    rst  = 1'b1;
    @(negedge clk);
    rst  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int n = 0; n < 3; n++) begin
      req = 4'($urandom);
      din = $urandom;
      @(negedge clk);
      checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
      checks++; if (bus_en !== 1'b0) begin errors++; $display("FAIL reset_bus_en: got %b expected 0", bus_en); end
      checks++; if (owner !== 2'd0) begin errors++; $display("FAIL reset_owner: got %0d expected 0", owner); end
    end
    req = '0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL idle_gnt: got %b expected 0000", gnt); end
    checks++; if (bus_en !== 1'b0) begin errors++; $display("FAIL idle_bus_en: got %b expected 0", bus_en); end
  endtask

  task automatic test_single();
    logic drv;
    do_reset();
    din = {8'h00, 8'hA5, 8'h00, 8'h00};
    req = 4'b0100;
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      drv = (c % 9) < 8;
      checks++; if (bus_en !== drv) begin errors++; $display("FAIL single_bus_en c=%0d: got %b expected %b", c, bus_en, drv); end
      checks++; if (gnt !== (drv ? 4'b0100 : 4'b0000)) begin errors++; $display("FAIL single_gnt c=%0d: got %b expected %b", c, gnt, drv ? 4'b0100 : 4'b0000); end
      checks++; if (owner !== 2'd2) begin errors++; $display("FAIL single_owner c=%0d: got %0d expected 2", c, owner); end
      if (drv) begin
        checks++; if (bus !== 8'hA5) begin errors++; $display("FAIL single_bus c=%0d: got %h expected a5", c, bus); end
      end
    end
  endtask

  task automatic test_contention();
    logic       drv;
    logic [1:0] own;
    logic [7:0] val [4];
    val[0] = 8'h10; val[1] = 8'h21; val[2] = 8'h32; val[3] = 8'h43;
    do_reset();
    din = {val[3], val[2], val[1], val[0]};
    req = 4'b1111;
    for (int c = 0; c < 45; c++) begin
      @(negedge clk);
      drv = (c % 9) < 8;
      own = 2'((c / 9) % 4);
      checks++; if (bus_en !== drv) begin errors++; $display("FAIL cont_bus_en c=%0d: got %b expected %b", c, bus_en, drv); end
      checks++; if (gnt !== (drv ? (4'b0001 << own) : 4'b0000)) begin errors++; $display("FAIL cont_gnt c=%0d: got %b expected %b", c, gnt, drv ? (4'b0001 << own) : 4'b0000); end
      checks++; if (owner !== own) begin errors++; $display("FAIL cont_owner c=%0d: got %0d expected %0d", c, owner, own); end
      checks++; if ($countones(gnt) > 1) begin errors++; $display("FAIL cont_onehot c=%0d: got %b expected at most one bit", c, gnt); end
      if (drv) begin
        checks++; if (bus !== val[own]) begin errors++; $display("FAIL cont_bus c=%0d: got %h expected %h", c, bus, val[own]); end
      end
    end
  endtask

  task automatic test_early_release();
    do_reset();
    din = {8'hC3, 8'h00, 8'h5A, 8'h00};
    req = 4'b1010;
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL early_gnt b=%0d: got %b expected 0010", b, gnt); end
      checks++; if (bus !== 8'h5A) begin errors++; $display("FAIL early_bus b=%0d: got %h expected 5a", b, bus); end
    end
    @(negedge clk);
    req = 4'b1000;
    #1;
    checks++; if (bus_en !== 1'b0) begin errors++; $display("FAIL early_drop_bus_en: got %b expected 0", bus_en); end
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL early_drop_gnt: got %b expected 0010", gnt); end
    @(negedge clk);
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL early_turn_gnt: got %b expected 0000", gnt); end
    checks++; if (bus_en !== 1'b0) begin errors++; $display("FAIL early_turn_bus_en: got %b expected 0", bus_en); end
    @(negedge clk);
    checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL early_next_gnt: got %b expected 1000", gnt); end
    checks++; if (owner !== 2'd3) begin errors++; $display("FAIL early_next_owner: got %0d expected 3", owner); end
    checks++; if (bus !== 8'hC3) begin errors++; $display("FAIL early_next_bus: got %h expected c3", bus); end
  endtask

  task automatic test_turn3();
    logic       drv;
    logic [1:0] own;
    do_reset();
    din3 = {8'h00, 8'h00, 8'h77, 8'h66};
    req3 = 4'b0011;
    for (int c = 0; c < 19; c++) begin
      @(negedge clk);
      drv = (c < 8) || (c >= 11);
      own = (c < 11) ? 2'd0 : 2'd1;
      checks++; if (bus_en3 !== drv) begin errors++; $display("FAIL turn3_bus_en c=%0d: got %b expected %b", c, bus_en3, drv); end
      checks++; if (gnt3 !== (drv ? (4'b0001 << own) : 4'b0000)) begin errors++; $display("FAIL turn3_gnt c=%0d: got %b expected %b", c, gnt3, drv ? (4'b0001 << own) : 4'b0000); end
      checks++; if (owner3 !== own) begin errors++; $display("FAIL turn3_owner c=%0d: got %0d expected %0d", c, owner3, own); end
      if (drv) begin
        checks++; if (bus3 !== ((own == 2'd0) ? 8'h66 : 8'h77)) begin errors++; $display("FAIL turn3_bus c=%0d: got %h expected %h", c, bus3, (own == 2'd0) ? 8'h66 : 8'h77); end
      end
    end
    req3 = '0;
  endtask

  task automatic test_async_reset();
    do_reset();
    din = {8'h00, 8'h3C, 8'h00, 8'h11};
    req = 4'b0100;
    @(negedge clk);
    checks++; if (bus !== 8'h3C) begin errors++; $display("FAIL arst_pre_bus: got %h expected 3c", bus); end
    req = 4'b0111;
    @(negedge clk);
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL arst_pre_gnt: got %b expected 0100", gnt); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus_en !== 1'b0) begin errors++; $display("FAIL arst_bus_en: got %b expected 0", bus_en); end
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL arst_gnt: got %b expected 0000", gnt); end
    checks++; if (owner !== 2'd0) begin errors++; $display("FAIL arst_owner: got %0d expected 0", owner); end
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL arst_regrant_gnt: got %b expected 0001", gnt); end
    checks++; if (bus !== 8'h11) begin errors++; $display("FAIL arst_regrant_bus: got %h expected 11", bus); end
    req = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_early_release();
    test_turn3();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
